// File: rtl/fsk_tx_framer.sv
// fsk_tx_framer: preamble / sync / payload / guard sequencer that
// feeds the FSK modulator one symbol per BIT_CYCLES clocks.
module fsk_tx_framer #(
  parameter int         BIT_CYCLES    = 32,
  parameter int         PREAMBLE_BITS = 8,
  parameter logic [7:0] SYNC_WORD     = 8'hD3,
  parameter int         GUARD_BITS    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       mod_bit,
  output logic       mod_en,
  output logic       busy,
  output logic       frame_done,
  output logic       err_underrun
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int MB = (PREAMBLE_BITS > GUARD_BITS)
                    ? PREAMBLE_BITS : GUARD_BITS;
  localparam int MX = (MB > 8) ? MB : 8;
  localparam int BW = $clog2(MX);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SYNC, DATA, GUARD
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cyc, cyc_d;
  logic [BW-1:0] bcnt, bcnt_d, last_idx;
  logic [7:0]    shreg, shreg_d;
  logic [7:0]    buf_data, buf_data_d;
  logic          buf_last, buf_last_d;
  logic          buf_full, buf_full_d;
  logic          cur_last, cur_last_d;
  logic          mod_bit_d, mod_en_d;
  logic          done_d, err_d;
  logic          bnd, bit_end, load, accept;

  assign busy    = (state != IDLE);
  assign accept  = s_valid & s_ready;
  assign bnd     = (cyc == CW'(BIT_CYCLES - 1));
  assign bit_end = bnd && (bcnt == last_idx);

  always_comb begin
    last_idx = BW'(7);
    unique case (state)
      PREAMBLE: last_idx = BW'(PREAMBLE_BITS - 1);
      GUARD:    last_idx = BW'(GUARD_BITS - 1);
      default:  last_idx = BW'(7);
    endcase
  end

  always_comb begin
    state_d    = state;
    cyc_d      = cyc;
    bcnt_d     = bcnt;
    shreg_d    = shreg;
    cur_last_d = cur_last;
    buf_data_d = buf_data;
    buf_last_d = buf_last;
    buf_full_d = buf_full;
    mod_bit_d  = mod_bit;
    mod_en_d   = mod_en;
    done_d     = 1'b0;
    err_d      = 1'b0;
    load       = 1'b0;

    if (state != IDLE) begin
      cyc_d = bnd ? '0 : cyc + CW'(1);
      if (bnd)
        bcnt_d = bit_end ? '0 : bcnt + BW'(1);
    end

    // shreg holds the sync word (MSB out) or payload (LSB out)
    unique case (state)
      IDLE: begin
        if (buf_full) begin
          state_d   = PREAMBLE;
          cyc_d     = '0;
          bcnt_d    = '0;
          mod_bit_d = 1'b1;
          mod_en_d  = 1'b1;
        end
      end
      PREAMBLE: begin
        if (bnd) begin
          if (bit_end) begin
            state_d   = SYNC;
            shreg_d   = SYNC_WORD;
            mod_bit_d = SYNC_WORD[7];
          end else begin
            mod_bit_d = !mod_bit;
          end
        end
      end
      SYNC: begin
        if (bnd) begin
          if (bit_end) begin
            state_d = DATA;
            load    = 1'b1;
          end else begin
            shreg_d   = shreg << 1;
            mod_bit_d = shreg[6];
          end
        end
      end
      DATA: begin
        if (bnd) begin
          if (!bit_end) begin
            shreg_d   = shreg >> 1;
            mod_bit_d = shreg[1];
          end else if (cur_last) begin
            state_d   = GUARD;
            mod_bit_d = 1'b0;
            mod_en_d  = 1'b0;
          end else if (buf_full) begin
            load = 1'b1;
          end else begin
            state_d   = GUARD;
            mod_bit_d = 1'b0;
            mod_en_d  = 1'b0;
            err_d     = 1'b1;
          end
        end
      end
      GUARD: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      buf_data_d = s_data;
      buf_last_d = s_last;
      buf_full_d = 1'b1;
    end
    if (load) begin
      shreg_d    = buf_data;
      cur_last_d = buf_last;
      mod_bit_d  = buf_data[0];
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cyc          <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      cur_last     <= 1'b0;
      buf_data     <= '0;
      buf_last     <= 1'b0;
      buf_full     <= 1'b0;
      s_ready      <= 1'b0;
      mod_bit      <= 1'b0;
      mod_en       <= 1'b0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      state        <= state_d;
      cyc          <= cyc_d;
      bcnt         <= bcnt_d;
      shreg        <= shreg_d;
      cur_last     <= cur_last_d;
      buf_data     <= buf_data_d;
      buf_last     <= buf_last_d;
      buf_full     <= buf_full_d;
      s_ready      <= !buf_full_d;
      mod_bit      <= mod_bit_d;
      mod_en       <= mod_en_d;
      frame_done   <= done_d;
      err_underrun <= err_d;
    end
  end

endmodule

// File: tb/tb_fsk_tx_framer.sv
// Scoreboard bench for fsk_tx_framer: random frames at default
// timing plus a directed back-to-back run on a fast instance.
module tb_fsk_tx_framer;

  localparam int BC  = 32;
  localparam int PB  = 8;
  localparam int GB  = 4;
  localparam int BC2 = 4;
  localparam int PB2 = 2;
  localparam int GB2 = 1;
  localparam logic [7:0] SW = 8'hD3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready, mod_bit, mod_en, busy;
  logic       frame_done, err_underrun;

  logic [7:0] s2_data = '0;
  logic       s2_last = 1'b0;
  logic       s2_valid = 1'b0;
  logic       s2_ready, s2_bit, s2_en, s2_busy;
  logic       s2_done, s2_err;

  fsk_tx_framer #(
    .BIT_CYCLES(BC), .PREAMBLE_BITS(PB),
    .SYNC_WORD(SW), .GUARD_BITS(GB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready),
    .mod_bit(mod_bit), .mod_en(mod_en), .busy(busy),
    .frame_done(frame_done), .err_underrun(err_underrun)
  );

  fsk_tx_framer #(
    .BIT_CYCLES(BC2), .PREAMBLE_BITS(PB2),
    .SYNC_WORD(SW), .GUARD_BITS(GB2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_data(s2_data), .s_last(s2_last),
    .s_valid(s2_valid), .s_ready(s2_ready),
    .mod_bit(s2_bit), .mod_en(s2_en), .busy(s2_busy),
    .frame_done(s2_done), .err_underrun(s2_err)
  );

  initial forever #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  exp_q[$];
  time start_q[$];
  time fd_time = 0;
  int  fd_count = 0;
  int  frames_sent = 0;
  int  en_e[$], bit_e[$], dn_e[$];

  function automatic void chk(input bit ok, input string nm,
                              input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // queue items: 0/1 symbol, 4/5 first payload bit of a byte,
  // 2 normal frame end, 3 frame end by underrun
  function automatic void push_hdr();
    logic [7:0] sw;
    sw = SW;
    for (int i = 0; i < PB; i++)
      exp_q.push_back((i % 2 == 0) ? 1 : 0);
    for (int i = 7; i >= 0; i--)
      exp_q.push_back(int'(sw[i]));
  endfunction

  function automatic void push_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++)
      exp_q.push_back(int'(d[i]) + ((i == 0) ? 4 : 0));
  endfunction

  initial begin : monitor
    bit  in_frame, in_guard, cur_bit, first;
    int  phase, g, v;
    time a, te;
    in_frame = 0; in_guard = 0; cur_bit = 0;
    phase = 0; g = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0; in_guard = 0; phase = 0;
        fd_time = 0; fd_count = 0;
      end else if (mod_en) begin
        if (!in_frame) begin
          in_frame = 1; phase = 0;
          chk(!in_guard, "guard_cut", in_guard, 0);
          in_guard = 0;
          if (start_q.size() == 0) begin
            chk(0, "start_unexpected", $time - 5, 0);
          end else begin
            a  = start_q.pop_front();
            te = ((a > fd_time) ? a : fd_time) + 10;
            chk($time - 5 == te, "start_time", $time - 5, te);
          end
        end
        if (phase == 0) begin
          first = 0;
          if (exp_q.size() == 0) begin
            chk(0, "symbol_unexpected", mod_bit, -1);
            cur_bit = 0;
          end else begin
            v = exp_q.pop_front();
            if (v == 2 || v == 3)
              chk(0, "frame_too_long", v, 0);
            cur_bit = v[0];
            first = (v >= 4);
          end
          if (first)
            chk(s_ready == 1, "ready_on_load", s_ready, 1);
        end
        chk(mod_bit == cur_bit, "symbol", mod_bit, cur_bit);
        chk(busy && !frame_done && !err_underrun, "frame_flags",
            {busy, frame_done, err_underrun}, 4);
        phase = (phase + 1) % BC;
      end else if (in_frame) begin
        in_frame = 0; in_guard = 1; g = 0;
        chk(phase == 0, "bit_align", phase, 0);
        v = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        chk(v == 2 || v == 3, "frame_end", v, 2);
        chk(err_underrun == (v == 3), "underrun",
            err_underrun, (v == 3));
        chk(!mod_bit && busy, "guard_entry", {busy, mod_bit}, 2);
      end else if (in_guard) begin
        g++;
        if (g == GB * BC) begin
          chk(frame_done && !busy, "frame_done",
              {frame_done, busy}, 2);
          in_guard = 0;
          fd_time = $time - 5;
          fd_count++;
        end else begin
          chk(!frame_done && busy && !mod_bit && !err_underrun,
              "guard", {frame_done, busy, mod_bit, err_underrun}, 4);
        end
      end else begin
        chk(!frame_done && !err_underrun && !mod_bit, "idle",
            {frame_done, err_underrun, mod_bit}, 0);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l,
                      input bit rnd, output time at);
    bit okv;
    s_data = d; s_last = l; at = 0;
    for (int j = 0; j < 4000; j++) begin
      s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      okv = s_valid && s_ready;
      @(posedge clk);
      if (okv) begin
        at = $time;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    if (at == 0) chk(0, "accept_timeout", 0, 1);
    else chk(s_ready == 0, "ready_drop", s_ready, 0);
  endtask

  task automatic wait_done();
    int j;
    j = 0;
    while (fd_count < frames_sent && j < 20000) begin
      @(negedge clk);
      j++;
    end
    chk(fd_count >= frames_sent, "done_timeout",
        fd_count, frames_sent);
  endtask

  task automatic small_test();
    logic [7:0] b2 [2];
    logic [7:0] sw;
    int k;
    sw = SW;
    b2[0] = 8'h96; b2[1] = 8'h4B;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < PB2; i++)
        repeat (BC2) begin
          en_e.push_back(1); bit_e.push_back((i % 2 == 0) ? 1 : 0);
          dn_e.push_back(0);
        end
      for (int i = 7; i >= 0; i--)
        repeat (BC2) begin
          en_e.push_back(1); bit_e.push_back(int'(sw[i]));
          dn_e.push_back(0);
        end
      for (int i = 0; i < 8; i++)
        repeat (BC2) begin
          en_e.push_back(1); bit_e.push_back(int'(b2[f][i]));
          dn_e.push_back(0);
        end
      repeat (GB2 * BC2) begin
        en_e.push_back(0); bit_e.push_back(0); dn_e.push_back(0);
      end
      en_e.push_back(0); bit_e.push_back(0); dn_e.push_back(1);
    end
    fork
      begin
        bit okv;
        for (int f = 0; f < 2; f++) begin
          s2_data = b2[f]; s2_last = 1'b1; s2_valid = 1'b1;
          for (int j = 0; j < 400; j++) begin
            okv = s2_ready;
            @(posedge clk);
            if (okv) break;
            @(negedge clk);
          end
          @(negedge clk);
        end
        s2_valid = 1'b0;
      end
      begin
        k = 0;
        while (!s2_en && k < 50) begin
          @(negedge clk);
          k++;
        end
        chk(s2_en, "small_start", s2_en, 1);
        for (int i = 0; i < en_e.size(); i++) begin
          chk(s2_en == en_e[i] && s2_bit == bit_e[i] &&
              s2_done == dn_e[i] && !s2_err, "small_wave",
              {s2_en, s2_bit, s2_done, s2_err},
              {en_e[i][0], bit_e[i][0], dn_e[i][0], 1'b0});
          @(negedge clk);
        end
      end
    join
  endtask

  initial begin : main
    time at;
    int n, k;
    logic [7:0] d;

    repeat (2) @(negedge clk);
    chk({s_ready, mod_bit, mod_en, busy, frame_done,
         err_underrun} == 0, "reset_values",
        {s_ready, mod_bit, mod_en, busy, frame_done, err_underrun}, 0);
    chk({s2_ready, s2_bit, s2_en, s2_busy, s2_done, s2_err} == 0,
        "reset_values_small",
        {s2_ready, s2_bit, s2_en, s2_busy, s2_done, s2_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk(s_ready == 1, "ready_after_reset", s_ready, 1);
    chk(s2_ready == 1, "ready_after_reset_small", s2_ready, 1);

    small_test();

    frames_sent++;
    push_hdr(); push_byte(8'hA5); exp_q.push_back(2);
    send(8'hA5, 1'b1, 1'b0, at); start_q.push_back(at);

    frames_sent++;
    push_hdr(); push_byte(8'h01);
    send(8'h01, 1'b0, 1'b0, at); start_q.push_back(at);
    push_byte(8'h80); exp_q.push_back(2);
    send(8'h80, 1'b1, 1'b0, at);

    frames_sent++;
    push_hdr(); push_byte(8'h3C); exp_q.push_back(3);
    send(8'h3C, 1'b0, 1'b1, at); start_q.push_back(at);
    wait_done();

    for (int f = 0; f < 8; f++) begin
      frames_sent++;
      n = $urandom_range(1, 3);
      push_hdr();
      for (int b = 0; b < n; b++) begin
        d = 8'($urandom);
        push_byte(d);
        if (b == n - 1) exp_q.push_back(2);
        send(d, (b == n - 1), 1'b1, at);
        if (b == 0) start_q.push_back(at);
      end
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    wait_done();

    frames_sent++;
    push_hdr(); push_byte(8'hFF); exp_q.push_back(2);
    send(8'hFF, 1'b1, 1'b0, at); start_q.push_back(at);
    k = 0;
    while (!mod_en && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (600) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({mod_bit, mod_en, busy, s_ready, frame_done,
         err_underrun} == 0, "async_reset",
        {mod_bit, mod_en, busy, s_ready, frame_done, err_underrun}, 0);
    exp_q.delete(); start_q.delete(); frames_sent = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(s_ready == 1, "ready_after_abort", s_ready, 1);

    frames_sent++;
    d = 8'($urandom);
    push_hdr(); push_byte(d); exp_q.push_back(2);
    send(d, 1'b1, 1'b1, at); start_q.push_back(at);
    wait_done();
    repeat (4) @(negedge clk);
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
